// File: rtl/scaler_pkg.sv
// scaler_pkg
// Shared constants and types for the horizontal scaler step controller.
// Step values are unsigned 4.12 fixed point; PIXEL_STEP represents 1.0.
package scaler_pkg;

    localparam int FRAC_W     = 12;
    localparam int PIXEL_STEP = 1 << FRAC_W;
    localparam int STEP_W     = 16;
    localparam int DIM_W      = 13;

    // Dividend is in_w * PIXEL_STEP, i.e. in_w shifted up by FRAC_W.
    localparam int DVD_W      = DIM_W + FRAC_W;
    localparam int CNT_W      = $clog2(STEP_W + 1);

    localparam logic [STEP_W-1:0] RESET_STEP = STEP_W'(PIXEL_STEP);
    localparam logic [STEP_W-1:0] CLAMP_STEP = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/scaler_step_div.sv
// scaler_step_div
// Sequential restoring divider producing one quotient bit per cycle, MSB
// first, with a fixed STEP_W-cycle latency from start to done.
// The caller guarantees dividend >> STEP_W is below the divisor, so the
// quotient always fits in STEP_W bits.
//
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset
//   start     load operands and begin a division (ignored while busy only
//             by the caller; a start always restarts)
//   dividend  DVD_W-bit numerator
//   divisor   DIM_W-bit denominator, non-zero
//   quotient  STEP_W-bit result, valid when done pulses and held afterwards
//   done      one-cycle pulse after the last quotient bit is formed
module scaler_step_div
    import scaler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DVD_W-1:0]  dividend,
    input  logic [DIM_W-1:0]  divisor,
    output logic [STEP_W-1:0] quotient,
    output logic              done
);

    logic [DIM_W:0]    rem_q;
    logic [STEP_W-1:0] shift_q;
    logic [DIM_W-1:0]  dsr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DIM_W:0]    rem_sh;
    logic [DIM_W:0]    rem_sub;
    logic              fits;

    // The remainder stays below the divisor, so shifting in one dividend
    // bit never overflows DIM_W+1 bits.
    always_comb begin
        rem_sh  = (rem_q << 1) | (DIM_W + 1)'(shift_q[STEP_W-1]);
        fits    = rem_sh >= {1'b0, dsr_q};
        rem_sub = rem_sh - {1'b0, dsr_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q    <= '0;
            shift_q  <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q    <= (DIM_W + 1)'(dividend[DVD_W-1:STEP_W]);
                shift_q  <= dividend[STEP_W-1:0];
                dsr_q    <= divisor;
                cnt_q    <= CNT_W'(STEP_W);
                quotient <= '0;
            end else if (cnt_q != '0) begin
                rem_q    <= fits ? rem_sub : rem_sh;
                shift_q  <= shift_q << 1;
                quotient <= {quotient[STEP_W-2:0], fits};
                cnt_q    <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scaler_step_ctrl.sv
// scaler_step_ctrl
// Configuration controller for the horizontal cubic scaler. Accepts an
// input/output line width, computes floor(in_w*PIXEL_STEP/out_w) as a 4.12
// step, and commits it to the scaler only at a frame boundary so no frame
// is scaled with mixed steps.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   cfg_in_w      requested input line width (pixels)
//   cfg_out_w     requested output line width (pixels)
//   cfg_valid     config request, transfers when cfg_valid && cfg_ready
//   cfg_ready     controller can accept a config
//   de_i, vs_i    scaler input data enable / frame start (monitored)
//   scale_step_h  committed step to the scaler
//   pend_o        a computed step awaits a frame boundary
//   upd_o         one-cycle pulse on the cycle after a commit edge
//   err_o         last accepted config was clamped or rejected
//
// state | meaning
// IDLE  | nothing pending, ready for a config
// DIV   | divider running, config not accepted
// PEND  | step computed, waiting for de_i && vs_i; a new config replaces it
module scaler_step_ctrl
    import scaler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM_W-1:0]  cfg_in_w,
    input  logic [DIM_W-1:0]  cfg_out_w,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              de_i,
    input  logic              vs_i,
    output logic [STEP_W-1:0] scale_step_h,
    output logic              pend_o,
    output logic              upd_o,
    output logic              err_o
);

    state_t            state_q;
    state_t            state_d;

    logic              xfer;
    logic              cfg_zero;
    logic              cfg_clamp;
    logic              div_start;
    logic              commit;
    logic [STEP_W-1:0] div_quot;
    logic              div_done;
    logic [STEP_W-1:0] pend_step_q;

    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_zero  = (cfg_in_w == '0) || (cfg_out_w == '0);
    // in_w >= out_w*16 means the step would reach 16.0 and not fit in 4.12.
    assign cfg_clamp = (DIM_W + 4)'(cfg_in_w) >= {cfg_out_w, 4'b0000};
    assign div_start = xfer && !cfg_zero && !cfg_clamp;
    assign commit    = (state_q == PEND) && de_i && vs_i;

    scaler_step_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({cfg_in_w, {FRAC_W{1'b0}}}),
        .divisor  (cfg_out_w),
        .quotient (div_quot),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A transfer in PEND is handled exactly like one in IDLE; any commit
    // on the same edge uses the old pending step in the datapath below.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, PEND: begin
                if (xfer) begin
                    if (cfg_zero) begin
                        state_d = IDLE;
                    end else if (cfg_clamp) begin
                        state_d = PEND;
                    end else begin
                        state_d = DIV;
                    end
                end else if (commit) begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = PEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b1;
        pend_o    = 1'b0;
        case (state_q)
            DIV:     cfg_ready = 1'b0;
            PEND:    pend_o    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scale_step_h <= RESET_STEP;
            pend_step_q  <= RESET_STEP;
            upd_o        <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            upd_o <= commit;
            if (commit) begin
                scale_step_h <= pend_step_q;
            end
            if (xfer) begin
                err_o <= cfg_zero || cfg_clamp;
            end
            if (xfer && !cfg_zero && cfg_clamp) begin
                pend_step_q <= CLAMP_STEP;
            end else if ((state_q == DIV) && div_done) begin
                pend_step_q <= div_quot;
            end
        end
    end

endmodule
